// File: rtl/serial_tx_arbiter_pkg.sv
// Shared types and limits for the serial transmit arbiter.
// State encodings, parameter bounds and the round-robin pointer advance.
package serial_arb_pkg;

    localparam int N_REQ_MIN  = 2;
    localparam int N_REQ_MAX  = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ACK   = 3'd4,
        ST_HOLD  = 3'd5,
        ST_ABORT = 3'd6
    } state_e;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/serial_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request scanning from ptr_i upward, wrapping.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic             valid_o,
    output logic [PW-1:0]    winner_o
);

    logic [PW:0] idx;

    // Scan from the farthest offset down so the closest hit to ptr_i is written last.
    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        idx      = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, ptr_i} + (PW+1)'(i);
            if (idx >= (PW+1)'(N_REQ))
                idx = idx - (PW+1)'(N_REQ);
            if (req_i[idx[PW-1:0]]) begin
                valid_o  = 1'b1;
                winner_o = idx[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte requesters, round-robin, with lock-held grants.
// Optional WAIT watchdog with ABORT state and timeout_err port: define SERIAL_ARB_TIMEOUT_EN.
module serial_tx_arbiter
    import serial_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = DATA_W_DEF
`ifdef SERIAL_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 100000
`endif
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        lock,
    input  logic [N_REQ*DATA_W-1:0] data_in,
    input  logic                    tx_done,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       tx_data,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        ack,
`ifdef SERIAL_ARB_TIMEOUT_EN
    output logic                    timeout_err,
`endif
    output logic                    busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < N_REQ_MIN || N_REQ > N_REQ_MAX) begin : g_bad_n_req
        $error("serial_tx_arbiter: N_REQ out of range");
    end

    state_e            state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              pick_vld;
    logic [PW-1:0]     pick_idx;
    logic [PW-1:0]     owner_nxt;
    logic [N_REQ-1:0]  owner_oh;
    logic              wait_expired;

    rr_picker #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_picker (
        .req_i    (req),
        .ptr_i    (rr_ptr_q),
        .valid_o  (pick_vld),
        .winner_o (pick_idx)
    );

    assign owner_nxt = PW'(rr_next(int'(owner_q), N_REQ));
    assign owner_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;

`ifdef SERIAL_ARB_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;

    // Counter idles at zero outside WAIT, so it is implicitly cleared on WAIT entry.
    assign tmo_cnt_d    = (state_q == ST_WAIT) ? tmo_cnt_q + 32'd1 : 32'd0;
    assign wait_expired = (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) tmo_cnt_q <= '0;
        else       tmo_cnt_q <= tmo_cnt_d;
    end

    assign timeout_err = (state_q == ST_ABORT);
`else
    assign wait_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        tx_data_d = tx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    owner_d = pick_idx;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_data_d = data_in[int'(owner_q)*DATA_W +: DATA_W];
                state_d   = ST_START;
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                // A done arriving on the expiry cycle still counts as success.
                if (tx_done)           state_d = ST_ACK;
                else if (wait_expired) state_d = ST_ABORT;
            end
            ST_ACK: begin
                if (lock[owner_q]) begin
                    state_d = ST_HOLD;
                end else begin
                    rr_ptr_d = owner_nxt;
                    state_d  = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (req[owner_q]) begin
                    state_d = ST_LOAD;
                end else if (!lock[owner_q]) begin
                    rr_ptr_d = owner_nxt;
                    state_d  = ST_IDLE;
                end
            end
            ST_ABORT: begin
                rr_ptr_d = owner_nxt;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign tx_start = (state_q == ST_START);
    assign tx_data  = tx_data_q;
    assign grant    = (busy && state_q != ST_ABORT) ? owner_oh : '0;
    assign ack      = (state_q == ST_ACK) ? owner_oh : '0;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Self-checking bench for serial_tx_arbiter: directed scenarios plus randomized round-robin traffic.
module tb_serial_tx_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  lock = '0;
    logic [31:0] data_in = '0;
    logic        tx_done = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        busy;
`ifdef SERIAL_ARB_TIMEOUT_EN
    logic        timeout_err;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int mptr   = 0;

    serial_tx_arbiter #(
        .N_REQ  (4),
        .DATA_W (8)
`ifdef SERIAL_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .lock     (lock),
        .data_in  (data_in),
        .tx_done  (tx_done),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .grant    (grant),
        .ack      (ack),
`ifdef SERIAL_ARB_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .busy     (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    // Round-robin rule: first pending requester at ptr, ptr+1, ... mod 4.
    function automatic int rr_pick(input logic [3:0] pend, input int ptr);
        for (int k = 0; k < 4; k++)
            if (pend[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] oh(input int i);
        logic [3:0] v;
        v = 4'b0001;
        return v << i;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (tx_start) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        n_chk++; if ({busy, tx_start} !== 2'b00) $display("FAIL reset_busy_start: got %b want 00", {busy, tx_start}); else n_pass++;
        n_chk++; if ({grant, ack} !== 8'h00) $display("FAIL reset_grant_ack: got %h want 00", {grant, ack}); else n_pass++;
        n_chk++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data); else n_pass++;
        reset = 1'b0;
        mptr  = 0;
        tick();
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_idle_no_req: busy got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_single;
        data_in[7:0] = 8'h41;
        req = 4'b0001;
        tick();
        n_chk++; if ({grant, tx_start, busy} !== {4'b0001, 1'b0, 1'b1}) $display("FAIL single_load: got %b want 000101", {grant, tx_start, busy}); else n_pass++;
        tick();
        n_chk++; if (tx_start !== 1'b1) $display("FAIL single_start: got %b want 1", tx_start); else n_pass++;
        n_chk++; if (tx_data !== 8'h41) $display("FAIL single_data: got %h want 41", tx_data); else n_pass++;
        tick();
        n_chk++; if (tx_start !== 1'b0) $display("FAIL single_start_pulse: got %b want 0", tx_start); else n_pass++;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        n_chk++; if (ack !== 4'b0001) $display("FAIL single_ack: got %b want 0001", ack); else n_pass++;
        req = 4'b0000;
        tick();
        n_chk++; if ({busy, ack} !== 5'b0) $display("FAIL single_done_idle: got %b want 00000", {busy, ack}); else n_pass++;
        mptr = 1;
    endtask

    task automatic test_rr;
        bit ok;
        int w;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mptr = 0;
        for (int i = 0; i < 4; i++) data_in[i*8 +: 8] = 8'hA0 + 8'(i);
        req = 4'b1011;
        for (int s = 0; s < 4; s++) begin
            wait_start(ok);
            n_chk++; if (!ok) $display("FAIL rr_start_timeout: step %0d got none want tx_start", s); else n_pass++;
            w = rr_pick(req, mptr);
            n_chk++; if (grant !== oh(w)) $display("FAIL rr_grant: step %0d got %b want %b", s, grant, oh(w)); else n_pass++;
            n_chk++; if (tx_data !== 8'hA0 + 8'(w)) $display("FAIL rr_data: step %0d got %h want %h", s, tx_data, 8'hA0 + 8'(w)); else n_pass++;
            tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            n_chk++; if (ack !== oh(w)) $display("FAIL rr_ack: step %0d got %b want %b", s, ack, oh(w)); else n_pass++;
            mptr = (w + 1) % 4;
            if (s == 3) req = 4'b0000;
            tick();
            n_chk++; if (ack !== 4'b0000) $display("FAIL rr_ack_once: step %0d got %b want 0000", s, ack); else n_pass++;
        end
    endtask

    task automatic test_lock;
        bit ok;
        int w;
        wait_idle(ok);
        n_chk++; if (!ok) $display("FAIL lock_idle_timeout: busy got %b want 0", busy); else n_pass++;
        data_in[0*8 +: 8] = 8'h77;
        data_in[2*8 +: 8] = 8'h10;
        lock = 4'b0100;
        req  = 4'b0101;
        w = rr_pick(req, mptr);
        for (int b = 0; b < 3; b++) begin
            wait_start(ok);
            n_chk++; if (!ok) $display("FAIL lock_start_timeout: byte %0d", b); else n_pass++;
            n_chk++; if (grant !== oh(w)) $display("FAIL lock_grant: byte %0d got %b want %b", b, grant, oh(w)); else n_pass++;
            n_chk++; if (tx_data !== 8'h10 + 8'(b)) $display("FAIL lock_data: byte %0d got %h want %h", b, tx_data, 8'h10 + 8'(b)); else n_pass++;
            tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            n_chk++; if (ack !== oh(w)) $display("FAIL lock_ack: byte %0d got %b want %b", b, ack, oh(w)); else n_pass++;
            if (b == 0) begin
                req[2] = 1'b0;
                data_in[2*8 +: 8] = 8'h11;
                for (int h = 0; h < 3; h++) begin
                    tick();
                    n_chk++; if ({grant, busy, tx_start} !== {4'b0100, 1'b1, 1'b0}) $display("FAIL lock_hold: cycle %0d got %b want 010010", h, {grant, busy, tx_start}); else n_pass++;
                end
                req[2] = 1'b1;
            end else if (b == 1) begin
                data_in[2*8 +: 8] = 8'h12;
            end else begin
                req[2]  = 1'b0;
                lock[2] = 1'b0;
            end
        end
        mptr = (w + 1) % 4;
        wait_start(ok);
        n_chk++; if (!ok) $display("FAIL lock_after_start_timeout: req0 never started"); else n_pass++;
        w = rr_pick(req, mptr);
        n_chk++; if ({grant, tx_data} !== {oh(w), 8'h77}) $display("FAIL lock_after_grant: got %h want %h", {grant, tx_data}, {oh(w), 8'h77}); else n_pass++;
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        n_chk++; if (ack !== oh(w)) $display("FAIL lock_after_ack: got %b want %b", ack, oh(w)); else n_pass++;
        req  = 4'b0000;
        mptr = (w + 1) % 4;
        tick();
    endtask

    task automatic test_drop;
        bit ok;
        int starts;
        wait_idle(ok);
        n_chk++; if (!ok) $display("FAIL drop_idle_timeout: busy got %b want 0", busy); else n_pass++;
        data_in[1*8 +: 8] = 8'h5A;
        req = 4'b0010;
        tick();
        n_chk++; if (grant !== 4'b0010) $display("FAIL drop_load_grant: got %b want 0010", grant); else n_pass++;
        req = 4'b1000;
        wait_start(ok);
        n_chk++; if (!ok) $display("FAIL drop_start_timeout: withdrawn byte not started"); else n_pass++;
        n_chk++; if (tx_data !== 8'h5A) $display("FAIL drop_data: got %h want 5a", tx_data); else n_pass++;
        tick();
        req = 4'b0000;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        n_chk++; if (ack !== 4'b0010) $display("FAIL drop_ack: got %b want 0010", ack); else n_pass++;
        mptr = 2;
        starts = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (tx_start) starts++;
        end
        n_chk++; if ({starts, busy} !== {32'd0, 1'b0}) $display("FAIL drop_withdrawn: starts %0d busy %b want 0 0", starts, busy); else n_pass++;
    endtask

    task automatic test_reset_mid;
        bit ok;
        data_in[0*8 +: 8] = 8'h33;
        req = 4'b0001;
        wait_start(ok);
        n_chk++; if (!ok) $display("FAIL rstmid_start_timeout: no tx_start"); else n_pass++;
        tick();
        reset = 1'b1;
        #1;
        n_chk++; if ({busy, tx_start, grant, ack, tx_data} !== 18'd0) $display("FAIL rstmid_async: got %h want 0", {busy, tx_start, grant, ack, tx_data}); else n_pass++;
        req = 4'b0000;
        tick();
        n_chk++; if ({busy, tx_start, grant, ack, tx_data} !== 18'd0) $display("FAIL rstmid_edge: got %h want 0", {busy, tx_start, grant, ack, tx_data}); else n_pass++;
        reset = 1'b0;
        mptr = 0;
        data_in[3*8 +: 8] = 8'hC3;
        req = 4'b1000;
        tick();
        n_chk++; if (grant !== 4'b1000) $display("FAIL rstmid_grant3: got %b want 1000", grant); else n_pass++;
        wait_start(ok);
        n_chk++; if (!ok || tx_data !== 8'hC3) $display("FAIL rstmid_data3: got %h want c3", tx_data); else n_pass++;
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        n_chk++; if (ack !== 4'b1000) $display("FAIL rstmid_ack3: got %b want 1000", ack); else n_pass++;
        req  = 4'b0000;
        mptr = 0;
        tick();
    endtask

    task automatic test_random;
        bit ok;
        int w, d;
        logic [3:0] pend;
        logic [7:0] exp_data [4];
        for (int r = 0; r < 30; r++) begin
            wait_idle(ok);
            n_chk++; if (!ok) $display("FAIL rand_idle_timeout: round %0d", r); else n_pass++;
            for (int i = 0; i < 4; i++) begin
                exp_data[i] = 8'($urandom);
                data_in[i*8 +: 8] = exp_data[i];
            end
            pend = 4'($urandom_range(1, 15));
            req  = pend;
            for (int n = 0; n < 4 && pend != 4'b0; n++) begin
                wait_start(ok);
                n_chk++; if (!ok) $display("FAIL rand_start_timeout: round %0d", r); else n_pass++;
                w = rr_pick(pend, mptr);
                n_chk++; if (grant !== oh(w)) $display("FAIL rand_grant: round %0d got %b want %b", r, grant, oh(w)); else n_pass++;
                n_chk++; if (tx_data !== exp_data[w]) $display("FAIL rand_data: round %0d got %h want %h", r, tx_data, exp_data[w]); else n_pass++;
                // done during START must be ignored
                tx_done = 1'($urandom_range(0, 1));
                tick();
                tx_done = 1'b0;
                d = $urandom_range(0, 3);
                for (int k = 0; k < d; k++) begin
                    data_in[w*8 +: 8] = 8'($urandom);
                    tick();
                    n_chk++; if ({ack, tx_data} !== {4'b0000, exp_data[w]}) $display("FAIL rand_wait: round %0d got %h want %h", r, {ack, tx_data}, {4'b0000, exp_data[w]}); else n_pass++;
                end
                tx_done = 1'b1;
                tick();
                tx_done = 1'b0;
                n_chk++; if (ack !== oh(w)) $display("FAIL rand_ack: round %0d got %b want %b", r, ack, oh(w)); else n_pass++;
                req[w]  = 1'b0;
                pend[w] = 1'b0;
                mptr    = (w + 1) % 4;
            end
            tick();
        end
    endtask

`ifdef SERIAL_ARB_TIMEOUT_EN
    task automatic test_timeout;
        bit ok;
        int w, cnt;
        wait_idle(ok);
        req = 4'b0011;
        w = rr_pick(req, mptr);
        wait_start(ok);
        n_chk++; if (!ok || grant !== oh(w)) $display("FAIL tmo_grant: got %b want %b", grant, oh(w)); else n_pass++;
        tick();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (timeout_err) break;
            cnt++;
            tick();
        end
        n_chk++; if (cnt !== 16) $display("FAIL tmo_wait_cycles: got %0d want 16", cnt); else n_pass++;
        n_chk++; if ({timeout_err, ack, grant} !== 9'b1_0000_0000) $display("FAIL tmo_abort: got %b want 100000000", {timeout_err, ack, grant}); else n_pass++;
        req[w] = 1'b0;
        mptr = (w + 1) % 4;
        tick();
        n_chk++; if (timeout_err !== 1'b0) $display("FAIL tmo_pulse: got %b want 0", timeout_err); else n_pass++;
        w = rr_pick(req, mptr);
        wait_start(ok);
        n_chk++; if (!ok || grant !== oh(w)) $display("FAIL tmo_next_grant: got %b want %b", grant, oh(w)); else n_pass++;
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        n_chk++; if (ack !== oh(w)) $display("FAIL tmo_next_ack: got %b want %b", ack, oh(w)); else n_pass++;
        req = 4'b0000;
        mptr = (w + 1) % 4;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_lock();
        test_drop();
        test_reset_mid();
        test_random();
`ifdef SERIAL_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
